// File: rtl/power_rail_sequencer_pkg.sv
// Shared constants for the N-rail power sequencer.
// State encoding is fixed because it drives the debug LEDs.
package power_rail_sequencer_pkg;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_UP        = 3'd1;
    localparam logic [2:0] ST_SETTLE_UP = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_DOWN      = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    // Width of a rail index; never narrower than one bit.
    function automatic int fault_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/power_rail_sequencer_pg_sync.sv
// Two-flop synchroniser for the raw power-good inputs.
// Cleared asynchronously together with the sequencer.
module power_rail_sequencer_pg_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Capture the asynchronous inputs, then re-time once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/power_rail_sequencer.sv
// Brings rails up in index order, down in reverse order,
// and latches the first faulting rail for readback.
module power_rail_sequencer
    import power_rail_sequencer_pkg::*;
#(
    parameter int NUM_RAILS     = 4,
    parameter int TIMER_WIDTH   = 16,
    parameter int PG_TIMEOUT    = 16384,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                                sysclk,
    input  logic                                reset_INV,
    input  logic                                enable,
    input  logic [NUM_RAILS-1:0]                pg,
    input  logic                                clear_fault,
    output logic [NUM_RAILS-1:0]                rail_en,
    output logic                                all_good,
    output logic                                fault,
    output logic [fault_idx_w(NUM_RAILS)-1:0]   fault_rail,
    output logic [2:0]                          state
);

    localparam int IW = fault_idx_w(NUM_RAILS);
    localparam logic [TIMER_WIDTH-1:0] TO_LAST = TIMER_WIDTH'(PG_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] SC_LAST = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] T_MAX   = '1;
    localparam logic [IW-1:0]          IDX_LAST = IW'(NUM_RAILS - 1);

    logic [NUM_RAILS-1:0]   pg_s;
    logic [IW-1:0]          idx;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] timer_inc;
    logic [NUM_RAILS-1:0]   idx_oh;
    logic [NUM_RAILS-1:0]   below;
    logic [NUM_RAILS-1:0]   chk;
    logic                   pg_cur;
    logic                   low_hit;
    logic [IW-1:0]          low_idx;
    logic                   go_fault;
    logic                   go_abort;
    logic [IW-1:0]          go_fault_idx;

    power_rail_sequencer_pg_sync #(.WIDTH(NUM_RAILS)) u_pg_sync (
        .clk   (sysclk),
        .rst_n (reset_INV),
        .d     (pg),
        .q     (pg_s)
    );

    assign timer_inc = (timer == T_MAX) ? timer : timer + 1'b1;
    assign pg_cur    = |(idx_oh & pg_s);
    assign low_hit   = |(chk & ~pg_s);

    // Decode current rail index and the set of rails that must hold pg.
    always_comb begin
        idx_oh = '0;
        below  = '0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            idx_oh[j] = (idx == IW'(j));
            below[j]  = (IW'(j) < idx);
        end
        chk = '0;
        case (state)
            ST_UP:        chk = below;
            ST_SETTLE_UP: chk = below | idx_oh;
            ST_RUN:       chk = '1;
            default:      chk = '0;
        endcase
    end

    // Lowest monitored rail whose power-good has dropped.
    always_comb begin
        low_idx = '0;
        for (int j = NUM_RAILS - 1; j >= 0; j--) begin
            if (chk[j] && !pg_s[j]) low_idx = IW'(j);
        end
    end

    // Faults outrank a disable request; both lead to ramp-down.
    always_comb begin
        go_fault     = 1'b0;
        go_abort     = 1'b0;
        go_fault_idx = low_idx;
        case (state)
            ST_UP: begin
                if (low_hit) begin
                    go_fault = 1'b1;
                end else if (!pg_cur && timer == TO_LAST) begin
                    go_fault     = 1'b1;
                    go_fault_idx = idx;
                end else if (!enable) begin
                    go_abort = 1'b1;
                end
            end
            ST_SETTLE_UP, ST_RUN: begin
                if (low_hit) go_fault = 1'b1;
                else if (!enable) go_abort = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, rail enables, timer and fault latch.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state      <= ST_OFF;
            idx        <= '0;
            timer      <= '0;
            rail_en    <= '0;
            all_good   <= 1'b0;
            fault      <= 1'b0;
            fault_rail <= '0;
        end else if (go_fault || go_abort) begin
            state    <= ST_DOWN;
            rail_en  <= rail_en & ~idx_oh;
            timer    <= '0;
            all_good <= 1'b0;
            if (go_fault) begin
                fault      <= 1'b1;
                fault_rail <= go_fault_idx;
            end
        end else begin
            case (state)
                ST_OFF: begin
                    if (enable && !fault) begin
                        state   <= ST_UP;
                        idx     <= '0;
                        rail_en <= NUM_RAILS'(1);
                        timer   <= '0;
                    end
                end
                ST_UP: begin
                    if (pg_cur) begin
                        state <= ST_SETTLE_UP;
                        timer <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_SETTLE_UP: begin
                    if (timer == SC_LAST) begin
                        if (idx == IDX_LAST) begin
                            state    <= ST_RUN;
                            all_good <= 1'b1;
                        end else begin
                            state   <= ST_UP;
                            idx     <= idx + 1'b1;
                            rail_en <= rail_en | (idx_oh << 1);
                            timer   <= '0;
                        end
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_RUN: ;
                ST_DOWN: begin
                    if (timer == SC_LAST) begin
                        if (idx == '0) begin
                            state <= fault ? ST_FAULT : ST_OFF;
                        end else begin
                            idx     <= idx - 1'b1;
                            rail_en <= rail_en & ~(idx_oh >> 1);
                            timer   <= '0;
                        end
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_FAULT: begin
                    rail_en <= '0;
                    if (clear_fault && !enable) begin
                        fault      <= 1'b0;
                        fault_rail <= '0;
                        state      <= ST_OFF;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Scoreboard bench: stimulus pushes expected output events,
// a negedge monitor pops one per observed output change.
module tb_power_rail_sequencer;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam int SC = 4;
    localparam int FW = 2;
    // pg reaches the synchroniser 3 edges after rail_en,
    // the sequencer reacts 2 edges later.
    localparam int T_PG = 5;
    localparam int BUDGET = 400;

    localparam int S_OFF = 0, S_UP = 1, S_SET = 2;
    localparam int S_RUN = 3, S_DOWN = 4, S_FAULT = 5;

    typedef struct {
        logic [N-1:0]  en;
        logic [2:0]    st;
        logic          f;
        logic [FW-1:0] fr;
        logic          ag;
        int            dt;
    } ev_t;

    logic          sysclk = 1'b0;
    logic          reset_INV;
    logic          enable;
    logic          clear_fault;
    logic [N-1:0]  pg;
    logic [N-1:0]  pg_low;
    logic [N-1:0]  rail_en;
    logic          all_good;
    logic          fault;
    logic [FW-1:0] fault_rail;
    logic [2:0]    state;

    logic [N-1:0]  h1 = '0;
    logic [N-1:0]  h2 = '0;
    int            cyc = 0;
    int            last_cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    ev_t           q[$];
    ev_t           e;
    logic [N+FW+4:0] prev = '0;
    logic [N+FW+4:0] cur;
    logic [N+FW+4:0] want;

    power_rail_sequencer #(
        .NUM_RAILS(N), .TIMER_WIDTH(16),
        .PG_TIMEOUT(TO), .SETTLE_CYCLES(SC)
    ) dut (
        .sysclk(sysclk), .reset_INV(reset_INV), .enable(enable),
        .pg(pg), .clear_fault(clear_fault), .rail_en(rail_en),
        .all_good(all_good), .fault(fault),
        .fault_rail(fault_rail), .state(state)
    );

    initial forever #5 sysclk = ~sysclk;

    // Board model: each rail's pg follows its enable with delay.
    always @(posedge sysclk) begin
        h1  <= rail_en;
        h2  <= h1;
        cyc <= cyc + 1;
    end
    assign pg = h2 & ~pg_low;

    function automatic logic [N-1:0] bits(input int k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < k; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic push_ev(input logic [N-1:0] en, input int st,
                           input bit f, input int fr, input bit ag,
                           input int dt);
        ev_t x;
        x.en = en; x.st = st[2:0]; x.f = f;
        x.fr = fr[FW-1:0]; x.ag = ag; x.dt = dt;
        q.push_back(x);
    endtask

    // Ramp-up: rail k enabled at 9k, settle entered T_PG later.
    task automatic exp_up(input int first_dt, input int stop_rail,
                          input int stop_phase);
        for (int k = 0; k < N; k++) begin
            push_ev(bits(k + 1), S_UP, 0, 0, 0, (k == 0) ? first_dt : SC);
            if (k == stop_rail && stop_phase == 0) return;
            push_ev(bits(k + 1), S_SET, 0, 0, 0, T_PG);
            if (k == stop_rail && stop_phase == 1) return;
        end
        push_ev(bits(N), S_RUN, 0, 0, 1, SC);
    endtask

    // Ramp-down from rails 0..top, one rail per settle period.
    task automatic exp_down(input int top, input bit f, input int fr,
                            input int first_dt);
        push_ev(bits(top), S_DOWN, f, fr, 0, first_dt);
        for (int k = top - 1; k >= 0; k--)
            push_ev(bits(k), S_DOWN, f, fr, 0, SC);
        push_ev('0, f ? S_FAULT : S_OFF, f, fr, 0, SC);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic wait_for(input int st, input logic [N-1:0] en,
                            input bit use_en);
        int n;
        n = 0;
        do begin
            @(negedge sysclk);
            n++;
        end while (!(state == st[2:0] && (!use_en || rail_en == en))
                   && n < BUDGET);
        if (!(state == st[2:0] && (!use_en || rail_en == en))) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_state: got st=%0d en=%b, required st=%0d",
                     state, rail_en, st);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < BUDGET) begin
            @(negedge sysclk);
            n++;
        end
        repeat (3) @(negedge sysclk);
        chk("events_pending", q.size(), 0);
        q.delete();
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        @(negedge sysclk);
        clear_fault = 1'b0;
    endtask

    task automatic run_then_down();
        int w;
        wait_for(S_RUN, '0, 0);
        w = $urandom_range(0, 5);
        repeat (w) @(negedge sysclk);
        enable = 1'b0;
        exp_down(N - 1, 0, 0, w + 1);
        drain();
    endtask

    // Monitor: every output change must match the next expected event.
    always @(negedge sysclk) begin
        cur = {rail_en, state, fault, fault_rail, all_good};
        if (cur !== prev) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: got en=%b st=%0d f=%b fr=%0d ag=%b, required no change",
                         rail_en, state, fault, fault_rail, all_good);
            end else begin
                e = q.pop_front();
                want = {e.en, e.st, e.f, e.fr, e.ag};
                if (want !== cur) begin
                    n_bad++;
                    $display("FAIL event: got en=%b st=%0d f=%b fr=%0d ag=%b, required en=%b st=%0d f=%b fr=%0d ag=%b",
                             rail_en, state, fault, fault_rail, all_good,
                             e.en, e.st, e.f, e.fr, e.ag);
                end
                if (e.dt >= 0) begin
                    n_cmp++;
                    if (cyc - last_cyc != e.dt) begin
                        n_bad++;
                        $display("FAIL step_time: got %0d cycles, required %0d (st=%0d en=%b)",
                                 cyc - last_cyc, e.dt, e.st, e.en);
                    end
                end
            end
            last_cyc = cyc;
            prev = cur;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, j, a, ph, k;
        reset_INV = 1'b0;
        enable = 1'b0;
        clear_fault = 1'b0;
        pg_low = '0;
        repeat (3) @(negedge sysclk);
        chk("rst_rail_en", int'(rail_en), 0);
        chk("rst_state", int'(state), S_OFF);
        chk("rst_fault", int'(fault), 0);
        chk("rst_fault_rail", int'(fault_rail), 0);
        chk("rst_all_good", int'(all_good), 0);
        reset_INV = 1'b1;
        repeat (2) @(negedge sysclk);

        // Clean ramp up to RUN and back down.
        for (int it = 0; it < 2; it++) begin
            exp_up(-1, N - 1, 2);
            enable = 1'b1;
            run_then_down();
        end

        // A rail that never reports pg times out.
        for (int it = 0; it < 3; it++) begin
            r = (it == 0) ? 1 : int'($urandom_range(0, N - 1));
            pg_low = bits(r + 1) & ~bits(r);
            exp_up(-1, r, 0);
            exp_down(r, 1, r, TO);
            enable = 1'b1;
            wait_for(S_DOWN, '0, 0);
            enable = 1'b0;
            pulse_clear();
            drain();
            pg_low = '0;
            push_ev('0, S_OFF, 0, 0, 0, -1);
            pulse_clear();
            drain();
        end

        // pg glitch while running, then fault clearing rules.
        for (int it = 0; it < 2; it++) begin
            j = (it == 0) ? 0 : int'($urandom_range(0, N - 1));
            exp_up(-1, N - 1, 2);
            enable = 1'b1;
            wait_for(S_RUN, '0, 0);
            k = $urandom_range(0, 4);
            repeat (k) @(negedge sysclk);
            pg_low = bits(j + 1) & ~bits(j);
            exp_down(N - 1, 1, j, k + 3);
            repeat (5) @(negedge sysclk);
            pg_low = '0;
            drain();
            pulse_clear();
            repeat (3) @(negedge sysclk);
            chk("clr_en1_state", int'(state), S_FAULT);
            chk("clr_en1_fault", int'(fault), 1);
            chk("clr_en1_fault_rail", int'(fault_rail), j);
            chk("clr_en1_rail_en", int'(rail_en), 0);
            enable = 1'b0;
            push_ev('0, S_OFF, 0, 0, 0, -1);
            pulse_clear();
            drain();
        end

        // Disable mid ramp-up, re-enable during ramp-down.
        for (int it = 0; it < 4; it++) begin
            a  = (it == 0) ? 1 : int'($urandom_range(0, N - 1));
            ph = (it == 0) ? 1 : int'($urandom_range(0, 1));
            exp_up(-1, a, ph);
            enable = 1'b1;
            wait_for(ph ? S_SET : S_UP, bits(a + 1), 1);
            enable = 1'b0;
            exp_down(a, 0, 0, 1);
            k = $urandom_range(1, 3);
            repeat (k) @(negedge sysclk);
            enable = 1'b1;
            exp_up(1, N - 1, 2);
            run_then_down();
        end

        // Asynchronous reset in the middle of ramp-up.
        exp_up(-1, 1, 0);
        enable = 1'b1;
        wait_for(S_UP, bits(2), 1);
        push_ev('0, S_OFF, 0, 0, 0, -1);
        #2 reset_INV = 1'b0;
        #1;
        chk("async_rail_en", int'(rail_en), 0);
        chk("async_state", int'(state), S_OFF);
        enable = 1'b0;
        repeat (2) @(negedge sysclk);
        reset_INV = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("post_rst_rail_en", int'(rail_en), 0);
        chk("post_rst_state", int'(state), S_OFF);
        chk("post_rst_fault", int'(fault), 0);
        chk("post_rst_fault_rail", int'(fault_rail), 0);
        chk("post_rst_all_good", int'(all_good), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
